// File: rtl/maze_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | maze_pkg : shared flit layout, link FSM states and node-match helper   |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
package maze_pkg;

    localparam int ID_W   = 6;
    localparam int QOS_W  = 2;
    localparam int TYPE_W = 2;
    localparam int DATA_W = 16;
    localparam int FLIT_W = QOS_W + TYPE_W + 2 * ID_W + DATA_W;

    typedef struct packed {
        logic [QOS_W-1:0]  qos;
        logic [TYPE_W-1:0] kind;
        logic [ID_W-1:0]   src;
        logic [ID_W-1:0]   tgt;
        logic [DATA_W-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_FAULT  = 2'd2
    } link_state_e;

    function automatic logic flit_hits_node(input logic [ID_W-1:0] src,
                                            input logic [ID_W-1:0] tgt,
                                            input logic [ID_W-1:0] node);
        return (tgt == node) || (src == node);
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_irs_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | maze_irs_stage : one register slice that drops flits bound to/from a   |
// |                  faulted node on the way in                            |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
module maze_irs_stage
    import maze_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            pg_en,
    input  logic [ID_W-1:0] pg_node,
    input  logic            in_vld,
    input  flit_t           in_flit,
    output logic            out_vld,
    output flit_t           out_flit,
    output logic            kill
);

    assign kill = in_vld & pg_en & flit_hits_node(in_flit.src, in_flit.tgt, pg_node);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
        end else begin
            out_vld <= in_vld & ~kill;
        end
    end

    // Payload is only captured alongside a valid; no reset needed.
    always_ff @(posedge clk) begin
        if (in_vld) begin
            out_flit <= in_flit;
        end
    end

endmodule
`default_nettype wire

// File: rtl/maze_link_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | maze_link_pipe : multi-channel link delay pipe with fault-node kill,   |
// |                  per-channel drop counters and flush/fault tracking    |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
module maze_link_pipe
    import maze_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pg_en,
    input  logic [ID_W-1:0]              pg_node,
    input  logic                         cnt_clr,
    input  logic [NUM_CH-1:0]            in_vld,
    input  logic [NUM_CH-1:0][FLIT_W-1:0] in_flit,
    output logic [NUM_CH-1:0]            out_vld,
    output logic [NUM_CH-1:0][FLIT_W-1:0] out_flit,
    output logic [NUM_CH-1:0][CNT_W-1:0] drop_cnt,
    output logic                         link_busy,
    output logic                         flush_busy
);

    localparam int TMR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int KILL_W = $clog2(DEPTH + 2);
    localparam int SUM_W  = CNT_W + KILL_W;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DEPTH - 1);

    logic              stg_vld  [NUM_CH][DEPTH];
    logic              stg_kill [NUM_CH][DEPTH];
    flit_t             stg_flit [NUM_CH][DEPTH];
    logic [NUM_CH-1:0] tail_kill;
    logic [KILL_W-1:0] kill_sum [NUM_CH];
    logic [SUM_W-1:0]  cnt_sum  [NUM_CH];

    link_state_e       state, state_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic [ID_W-1:0]   cap_node, cap_node_nxt;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            for (genvar s = 0; s < DEPTH; s++) begin : g_stage
                logic  src_vld;
                flit_t src_flit;
                if (s == 0) begin : g_entry
                    assign src_vld  = in_vld[c];
                    assign src_flit = in_flit[c];
                end else begin : g_link
                    assign src_vld  = stg_vld[c][s-1];
                    assign src_flit = stg_flit[c][s-1];
                end
                maze_irs_stage u_stage (
                    .clk      (clk),
                    .rst      (rst),
                    .pg_en    (pg_en),
                    .pg_node  (pg_node),
                    .in_vld   (src_vld),
                    .in_flit  (src_flit),
                    .out_vld  (stg_vld[c][s]),
                    .out_flit (stg_flit[c][s]),
                    .kill     (stg_kill[c][s])
                );
            end
            // Last slice is checked at the port so a faulted flit never shows out_vld.
            assign tail_kill[c] = stg_vld[c][DEPTH-1] & pg_en &
                                  flit_hits_node(stg_flit[c][DEPTH-1].src,
                                                 stg_flit[c][DEPTH-1].tgt, pg_node);
            assign out_vld[c]  = stg_vld[c][DEPTH-1] & ~tail_kill[c];
            assign out_flit[c] = stg_flit[c][DEPTH-1];
        end
    endgenerate

    always_comb begin
        link_busy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            kill_sum[c] = KILL_W'(tail_kill[c]);
            for (int s = 0; s < DEPTH; s++) begin
                kill_sum[c] = kill_sum[c] + KILL_W'(stg_kill[c][s]);
                link_busy   = link_busy | stg_vld[c][s];
            end
            cnt_sum[c] = SUM_W'(drop_cnt[c]) + SUM_W'(kill_sum[c]);
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst || cnt_clr) begin
                drop_cnt[c] <= '0;
            end else if (|cnt_sum[c][SUM_W-1:CNT_W]) begin
                drop_cnt[c] <= '1;
            end else begin
                drop_cnt[c] <= cnt_sum[c][CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_NORMAL;
            timer    <= '0;
            cap_node <= '0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            cap_node <= cap_node_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        cap_node_nxt = cap_node;
        case (state)
            ST_NORMAL: begin
                if (pg_en) begin
                    state_nxt    = ST_FLUSH;
                    timer_nxt    = TMR_LOAD;
                    cap_node_nxt = pg_node;
                end
            end
            ST_FLUSH: begin
                if (!pg_en) begin
                    state_nxt = ST_NORMAL;
                end else if (timer == '0) begin
                    state_nxt = ST_FAULT;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            ST_FAULT: begin
                if (!pg_en) begin
                    state_nxt = ST_NORMAL;
                end else if (pg_node != cap_node) begin
                    state_nxt    = ST_FLUSH;
                    timer_nxt    = TMR_LOAD;
                    cap_node_nxt = pg_node;
                end
            end
            default: state_nxt = ST_NORMAL;
        endcase
    end

    assign flush_busy = (state == ST_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_maze_link_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_maze_link_pipe : directed and random checks of maze_link_pipe       |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_maze_link_pipe;

    localparam int NUM_CH  = 2;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int FW      = 32;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                           clk = 1'b0;
    logic                           rst, pg_en, cnt_clr;
    logic [5:0]                     pg_node;
    logic [NUM_CH-1:0]              in_vld, out_vld;
    logic [NUM_CH-1:0][FW-1:0]      in_flit, out_flit;
    logic [NUM_CH-1:0][CNT_W-1:0]   drop_cnt;
    logic                           link_busy, flush_busy;

    maze_link_pipe #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .pg_en(pg_en), .pg_node(pg_node), .cnt_clr(cnt_clr),
        .in_vld(in_vld), .in_flit(in_flit), .out_vld(out_vld), .out_flit(out_flit),
        .drop_cnt(drop_cnt), .link_busy(link_busy), .flush_busy(flush_busy)
    );

    always #5 clk = ~clk;

    // Reference: every in-flight flit is screened every cycle; it leaves after DEPTH cycles.
    typedef struct { int ch; logic [FW-1:0] f; int age; } rec_t;
    rec_t        q[$];
    int          m_drop [NUM_CH];
    int          m_state;       // 0 normal, 1 flush, 2 fault
    int          m_left;
    logic [5:0]  m_cap;

    logic [NUM_CH-1:0]         exp_vld, obs_vld;
    logic [NUM_CH-1:0][FW-1:0] exp_flit, obs_flit;
    int checks = 0;
    int errors = 0;

    function automatic logic [FW-1:0] mk(input logic [5:0] src, input logic [5:0] tgt,
                                         input logic [15:0] data);
        logic [1:0] qos;
        logic [1:0] kind;
        qos  = 2'($urandom);
        kind = 2'($urandom);
        return {qos, kind, src, tgt, data};
    endfunction

    function automatic bit hits(input logic [FW-1:0] f);
        logic [5:0] t;
        logic [5:0] s;
        t = f[21:16];
        s = f[27:22];
        return pg_en && ((t == pg_node) || (s == pg_node));
    endfunction

    task automatic model_update();
        rec_t nq[$];
        int   kills [NUM_CH];
        for (int c = 0; c < NUM_CH; c++) kills[c] = 0;
        if (rst) begin
            q.delete();
            for (int c = 0; c < NUM_CH; c++) m_drop[c] = 0;
            m_state = 0;
            m_left  = 0;
            m_cap   = '0;
            return;
        end
        foreach (q[i]) begin
            if (hits(q[i].f)) kills[q[i].ch]++;
            else if (q[i].age < DEPTH) nq.push_back('{ch: q[i].ch, f: q[i].f, age: q[i].age + 1});
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_vld[c]) begin
                if (hits(in_flit[c])) kills[c]++;
                else nq.push_back('{ch: c, f: in_flit[c], age: 1});
            end
        end
        q = nq;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cnt_clr) m_drop[c] = 0;
            else m_drop[c] = (m_drop[c] + kills[c] > CNT_MAX) ? CNT_MAX : m_drop[c] + kills[c];
        end
        case (m_state)
            0: if (pg_en) begin m_state = 1; m_left = DEPTH; m_cap = pg_node; end
            1: if (!pg_en) m_state = 0;
               else begin m_left--; if (m_left == 0) m_state = 2; end
            default: if (!pg_en) m_state = 0;
               else if (pg_node != m_cap) begin m_state = 1; m_left = DEPTH; m_cap = pg_node; end
        endcase
    endtask

    // Snapshot combinational outputs before the edge, advance model at the edge.
    task automatic tick();
        #2;
        exp_vld = '0;
        exp_flit = 'x;
        foreach (q[i]) begin
            if (q[i].age == DEPTH && !hits(q[i].f)) begin
                exp_vld[q[i].ch]  = 1'b1;
                exp_flit[q[i].ch] = q[i].f;
            end
        end
        obs_vld  = out_vld;
        obs_flit = out_flit;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pg_en = 1'b0; pg_node = '0; cnt_clr = 1'b0; in_vld = '0; in_flit = '0;
        tick();
        tick();
        checks++; if (out_vld !== '0) begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
        checks++; if (link_busy !== 1'b0) begin errors++; $display("FAIL reset_link_busy got %b want 0", link_busy); end
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_flush_busy got %b want 0", flush_busy); end
        checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt got %h want 0", drop_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_pass_through();
        logic [FW-1:0] f;
        f = mk(6'h05, 6'h12, 16'hBEEF);
        pg_en = 1'b0; in_vld = 2'b01; in_flit[0] = f;
        tick();
        in_vld = '0;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            tick();
            checks++;
            if (obs_vld[0] !== (k == DEPTH)) begin
                errors++; $display("FAIL pass_vld cycle %0d got %b want %b", k, obs_vld[0], k == DEPTH);
            end
            if (k == DEPTH) begin
                checks++;
                if (obs_flit[0] !== f) begin errors++; $display("FAIL pass_flit got %h want %h", obs_flit[0], f); end
            end
        end
        checks++; if (drop_cnt[0] !== '0) begin errors++; $display("FAIL pass_drop got %h want 0", drop_cnt[0]); end
    endtask

    task automatic test_kill_entry();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        pg_en = 1'b1; pg_node = 6'h09; in_vld = 2'b11;
        in_flit[1] = mk(6'h01, 6'h09, 16'h1111);
        in_flit[0] = mk(6'h01, 6'h0A, 16'h2222);
        tick();
        in_vld = '0;
        checks++; if (drop_cnt[1] !== 4'd1) begin errors++; $display("FAIL entry_drop1 got %h want 1", drop_cnt[1]); end
        checks++; if (drop_cnt[0] !== 4'd0) begin errors++; $display("FAIL entry_drop0 got %h want 0", drop_cnt[0]); end
        for (int k = 1; k <= DEPTH + 1; k++) begin
            tick();
            checks++;
            if (obs_vld[1] !== 1'b0) begin errors++; $display("FAIL entry_ch1_vld cycle %0d got %b want 0", k, obs_vld[1]); end
            checks++;
            if (obs_vld[0] !== (k == DEPTH)) begin
                errors++; $display("FAIL entry_ch0_vld cycle %0d got %b want %b", k, obs_vld[0], k == DEPTH);
            end
        end
        pg_en = 1'b0;
        tick();
    endtask

    task automatic test_inflight_kill();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        in_vld = 2'b01;
        for (int k = 0; k < 3; k++) begin
            in_flit[0] = mk(6'h01, 6'h21, 16'(k));
            tick();
        end
        in_vld = '0; pg_en = 1'b1; pg_node = 6'h21;
        tick();
        checks++; if (drop_cnt[0] !== 4'd3) begin errors++; $display("FAIL inflight_drop got %h want 3", drop_cnt[0]); end
        checks++; if (link_busy !== 1'b0) begin errors++; $display("FAIL inflight_busy got %b want 0", link_busy); end
        checks++; if (flush_busy !== 1'b1) begin errors++; $display("FAIL inflight_flush got %b want 1", flush_busy); end
        for (int k = 2; k <= DEPTH; k++) begin
            tick();
            checks++; if (flush_busy !== 1'b1) begin errors++; $display("FAIL flush_hold cycle %0d got %b want 1", k, flush_busy); end
        end
        tick();
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL fault_entry got %b want 0", flush_busy); end
    endtask

    task automatic test_fault_retarget();
        pg_node = 6'h22;
        tick();
        checks++; if (flush_busy !== 1'b1) begin errors++; $display("FAIL retarget_flush got %b want 1", flush_busy); end
        tick();
        checks++; if (flush_busy !== 1'b1) begin errors++; $display("FAIL retarget_hold got %b want 1", flush_busy); end
        pg_en = 1'b0;
        tick();
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL abort_flush got %b want 0", flush_busy); end
        pg_en = 1'b1;
        tick();
        checks++; if (flush_busy !== 1'b1) begin errors++; $display("FAIL normal_reentry got %b want 1", flush_busy); end
        pg_en = 1'b0;
        tick();
    endtask

    task automatic test_saturate_clear();
        pg_en = 1'b1; pg_node = 6'h05;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        in_vld = 2'b01;
        for (int k = 0; k < 17; k++) begin
            in_flit[0] = mk(6'h01, 6'h05, 16'($urandom));
            tick();
        end
        checks++; if (drop_cnt[0] !== 4'hF) begin errors++; $display("FAIL saturate got %h want f", drop_cnt[0]); end
        cnt_clr = 1'b1;
        tick();
        checks++; if (drop_cnt[0] !== 4'h0) begin errors++; $display("FAIL clear_wins got %h want 0", drop_cnt[0]); end
        cnt_clr = 1'b0;
        tick();
        checks++; if (drop_cnt[0] !== 4'h1) begin errors++; $display("FAIL after_clear got %h want 1", drop_cnt[0]); end
        in_vld = '0; pg_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_midtraffic();
        pg_en = 1'b1; pg_node = 6'h05;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        in_vld = 2'b01;
        for (int k = 0; k < 5; k++) begin
            in_flit[0] = mk(6'h02, 6'h05, 16'(k));
            tick();
        end
        checks++; if (drop_cnt[0] !== 4'd5) begin errors++; $display("FAIL mid_drop got %h want 5", drop_cnt[0]); end
        pg_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_flit[0] = mk(6'h01, 6'h30, 16'(k));
            tick();
        end
        in_vld = '0;
        checks++; if (link_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", link_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_vld !== '0) begin errors++; $display("FAIL mid_rst_vld got %b want 0", out_vld); end
        checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL mid_rst_drop got %h want 0", drop_cnt); end
        checks++; if (link_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", link_busy); end
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_flush got %b want 0", flush_busy); end
        for (int k = 1; k <= DEPTH + 2; k++) begin
            tick();
            checks++; if (obs_vld !== '0) begin errors++; $display("FAIL mid_rst_emerge cycle %0d got %b want 0", k, obs_vld); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(199) == 0);
            cnt_clr = ($urandom_range(39) == 0);
            if ($urandom_range(15) == 0) pg_en = ~pg_en;
            if ($urandom_range(7) == 0) pg_node = 6'($urandom_range(7));
            in_vld = NUM_CH'($urandom);
            for (int c = 0; c < NUM_CH; c++)
                in_flit[c] = mk(6'($urandom_range(7)), 6'($urandom_range(7)), 16'($urandom));
            tick();
            checks++;
            if (obs_vld !== exp_vld) begin errors++; $display("FAIL rnd_vld step %0d got %b want %b", n, obs_vld, exp_vld); end
            for (int c = 0; c < NUM_CH; c++) begin
                if (exp_vld[c]) begin
                    checks++;
                    if (obs_flit[c] !== exp_flit[c]) begin
                        errors++; $display("FAIL rnd_flit ch%0d step %0d got %h want %h", c, n, obs_flit[c], exp_flit[c]);
                    end
                end
                checks++;
                if (drop_cnt[c] !== CNT_W'(m_drop[c])) begin
                    errors++; $display("FAIL rnd_drop ch%0d step %0d got %0d want %0d", c, n, drop_cnt[c], m_drop[c]);
                end
            end
            checks++;
            if (link_busy !== (q.size() != 0)) begin errors++; $display("FAIL rnd_busy step %0d got %b want %b", n, link_busy, q.size() != 0); end
            checks++;
            if (flush_busy !== (m_state == 1)) begin errors++; $display("FAIL rnd_flush step %0d got %b want %b", n, flush_busy, m_state == 1); end
        end
        rst = 1'b0; cnt_clr = 1'b0; in_vld = '0;
    endtask

    initial begin
        m_state = 0; m_left = 0; m_cap = '0;
        for (int c = 0; c < NUM_CH; c++) m_drop[c] = 0;
        test_reset();
        test_pass_through();
        test_kill_entry();
        test_inflight_kill();
        test_fault_retarget();
        test_saturate_clear();
        test_reset_midtraffic();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maze_link_pipe.md
MAZE_LINK_PIPE -- requirements
Module: maze_link_pipe

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent link channels (x, y); legal 1..4.
REQ-002 Parameter DEPTH, default 2, register-slice stages per channel; legal 1..8.
REQ-003 Parameter CNT_W, default 16, width of each drop counter.
REQ-004 clk  input  1  single clock for all state.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pg_en  input  1  fault enable.
REQ-007 pg_node  input  ID_W  faulted node coordinate {vp,hp}.
REQ-008 cnt_clr  input  1  clears all drop counters.
REQ-009 in_vld  input  NUM_CH  per-channel flit valid.
REQ-010 in_flit  input  NUM_CH x FLIT_W  per-channel flit (qos, type, src, tgt, data).
REQ-011 out_vld  output  NUM_CH  per-channel delayed valid.
REQ-012 out_flit  output  NUM_CH x FLIT_W  per-channel delayed flit.
REQ-013 drop_cnt  output  NUM_CH x CNT_W  per-channel killed-flit count.
REQ-014 link_busy  output  1  any stage of any channel holds a valid flit.
REQ-015 flush_busy  output  1  FSM in FLUSH.

Function
REQ-016 Each channel SHALL be a DEPTH-stage shift pipeline without backpressure: a flit accepted at cycle t appears on out_* at cycle t+DEPTH, order preserved.
REQ-017 Stage data registers SHALL load only when the incoming valid is 1; valid bits SHALL shift every cycle.
REQ-018 A flit SHALL be killed (valid forced 0 at the next stage) when pg_en=1 and (flit.tgt==pg_node or flit.src==pg_node), evaluated at channel entry and between every pair of stages, using current pg_en/pg_node.
REQ-019 out_vld SHALL never assert for a flit matching REQ-018 while pg_en=1.
REQ-020 Each killed flit SHALL increment its channel's drop_cnt by 1; kills in several stages of one channel in the same cycle SHALL add the number of kills.
REQ-021 drop_cnt SHALL saturate at all-ones and not wrap.
REQ-022 cnt_clr=1 SHALL set all drop_cnt to 0 the next cycle; clear wins over same-cycle kills.
REQ-023 FSM states: NORMAL, FLUSH, FAULT.
REQ-024 NORMAL -> FLUSH when pg_en=1; timer loaded with DEPTH-1 and pg_node captured.
REQ-025 FLUSH: timer decrements each cycle; at timer 0 -> FAULT.
REQ-026 FAULT -> FLUSH (timer reloaded, pg_node recaptured) when pg_node differs from captured value.
REQ-027 FLUSH or FAULT -> NORMAL when pg_en=0, regardless of timer.
REQ-028 flush_busy SHALL equal (state==FLUSH); link_busy SHALL be the OR of all stage valids (registered state only, no input term).
REQ-029 Simultaneous in_vld and kill on entry SHALL count once and produce no stage valid.

Reset
REQ-030 rst=1 SHALL, at the next clk edge, clear all stage valids, drop_cnt, timer and captured node, and set state NORMAL; out_vld=0, link_busy=0, flush_busy=0, drop_cnt=0 thereafter.
REQ-031 Stage data registers need no reset; out_flit is don't-care while out_vld=0.
REQ-032 Reset mid-traffic SHALL discard all in-flight flits without counting them.

Structure
REQ-033 ID_W, QOS_W, TYPE_W, DATA_W, FLIT_W, the flit struct and FSM state enum SHALL live in shared package maze_pkg.
REQ-034 One sub-module maze_irs_stage (one register slice with kill compare and kill output) SHALL be instantiated NUM_CH x DEPTH times.

Verification
REQ-035 DEPTH=3, pg_en=0, flit tgt=6'h12 on ch0 at cycle 10 -> out_vld[0]=1 at cycle 13 with identical flit; drop_cnt=0.
REQ-036 pg_en=1, pg_node=6'h09, flit tgt=6'h09 on ch1 -> never emerges; drop_cnt[1]=1; flit tgt=6'h0A same cycle on ch0 emerges after DEPTH.
REQ-037 DEPTH=4, three flits tgt=6'h21 in stages 1..3, then pg_en=1 pg_node=6'h21 -> all killed in one cycle, drop_cnt=3, FSM NORMAL->FLUSH for 4 cycles ->FAULT, link_busy=0.
REQ-038 CNT_W=4, 17 killed flits -> drop_cnt=4'hF; cnt_clr with a same-cycle kill -> drop_cnt=0.
REQ-039 FAULT, pg_node changes 6'h21->6'h22 -> FLUSH for DEPTH cycles; pg_en=0 during FLUSH -> NORMAL next cycle.
REQ-040 rst=1 with 2 flits in flight and drop_cnt=5 -> next cycle out_vld=0, drop_cnt=0, state NORMAL; no flit emerges afterwards.
